lsu_core: RTL and testbench
===========================

LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter OUTPORT_ADDR, default 32'hfffc, address of the memory-mapped output port.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports: req_valid  in  1; req_ready  out  1; req_is_store  in  1; req_funct3  in  3  (load/store size code); req_addr  in  ADDR_W; req_wdata  in  XLEN.
REQ-007 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  XLEN  extended load data; resp_fault  out  1  access rejected.
REQ-008 SHALL have ports: mem_req_valid  out  1; mem_req_ready  in  1; mem_we  out  1; mem_addr  out  ADDR_W  XLEN/8-aligned; mem_wdata  out  XLEN; mem_be  out  XLEN/8  byte enables.
REQ-009 SHALL have ports: mem_rvalid  in  1; mem_rdata  in  XLEN.
REQ-010 SHALL have ports: outport  out  XLEN  output-port register.

Function
REQ-011 Size codes SHALL be: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; for XLEN=64 additionally 011 double, 110 word-unsigned. Any other code, and unsigned codes on stores, SHALL be illegal.
REQ-012 States SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-013 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid&&req_ready and its fields latched.
REQ-014 An illegal size code SHALL go IDLE->RESP with resp_fault=1, no memory beat, outport unchanged.
REQ-015 A store with req_addr==OUTPORT_ADDR and size word SHALL write req_wdata[31:0] zero-extended to outport and go IDLE->RESP with no memory beat.
REQ-016 Otherwise IDLE->REQ0; mem_req_valid SHALL be 1 in REQ0/REQ1 and held with stable mem_* until mem_req_ready.
REQ-017 mem_be SHALL select the accessed bytes within the aligned beat; mem_wdata SHALL be store data shifted to byte lane (addr mod XLEN/8).
REQ-018 After a handshake, stores SHALL proceed without waiting; loads SHALL wait in WAIT0/WAIT1 for mem_rvalid, any number of cycles.
REQ-019 An access is misaligned when addr is not a multiple of its size; a misaligned access never crosses more than one beat boundary.
REQ-020 Loads SHALL shift beat data down by lane offset, then sign-extend (signed codes) or zero-extend (unsigned codes) to XLEN.
REQ-021 resp_valid SHALL be 1 for exactly one cycle in RESP; RESP->IDLE unconditionally; resp_rdata SHALL be 0 for stores and faults.
REQ-022 Only one access SHALL be outstanding; mem_rvalid outside WAIT0/WAIT1 SHALL be ignored.
REQ-023 Minimum latency acceptance->resp_valid: aligned store 2 cycles, aligned load 3 cycles with zero-wait memory.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and clear req_ready-latched state.
REQ-025 During and after reset: resp_valid=0, resp_rdata=0, resp_fault=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, outport=0; req_ready=1 on first cycle after release.
REQ-026 Reset mid-access SHALL abandon the access with no response; a later mem_rvalid SHALL be ignored.

Configuration
REQ-027 Macro LSU_MISALIGN_SPLIT_EN: when defined, a misaligned access SHALL issue beat 0 at the aligned base (REQ0/WAIT0) then beat 1 at base+XLEN/8 (REQ1/WAIT1), with per-beat byte enables, and loads SHALL merge both beats before extension.
REQ-028 When LSU_MISALIGN_SPLIT_EN is undefined, a misaligned access SHALL go IDLE->RESP with resp_fault=1 and no memory beat; REQ1/WAIT1 SHALL be unreachable.

Verification
REQ-029 XLEN=32, load byte addr 0x103, mem_rdata=0x80FFFFFF zero-wait -> resp_rdata=0xFFFFFF80, resp_fault=0, resp_valid 3 cycles after accept.
REQ-030 Store word 0x12345678 to 0xfffc -> outport=0x12345678, no mem_req_valid, resp_valid next cycle.
REQ-031 Load half-unsigned addr 0x102, mem_req_ready low 4 cycles, data 0xBEEF0000 -> mem_addr stable at 0x100, resp_rdata=0x0000BEEF.
REQ-032 With LSU_MISALIGN_SPLIT_EN, load word addr 0x103, beats 0x11223344 then 0x55667788 -> mem_addr 0x100 then 0x104, resp_rdata=0x66778811; without macro -> resp_fault=1, no beat.
REQ-033 req_funct3=111 load -> resp_fault=1, resp_rdata=0; rst_n low while in WAIT0 then mem_rvalid -> no resp_valid, all outputs at reset values.

Source files
------------

// File: rtl/lsu_core.sv
// Load/store unit: one access at a time, byte-lane steering, load extension, memory-mapped output port.
// Optional macro LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two aligned beats.
module lsu_core #(
   parameter int                XLEN         = 32,
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] OUTPORT_ADDR = ADDR_W'(32'hfffc)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_be,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic [XLEN-1:0]   outport
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int BW = 2 * NB;

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t            state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              fault_q, fault_d;
   logic [XLEN-1:0]   beat0_q, beat0_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [XLEN-1:0]   outport_q, outport_d;

   logic [OW-1:0]     off;
   logic [BW-1:0]     be_full;
   logic [2*XLEN-1:0] wd_full;
   logic [ADDR_W-1:0] base;
   logic              beat1;
   logic              split_need;

   function automatic logic f3_legal(input logic [2:0] f3, input logic st);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = ~st;
         3'b011:                 ok = (XLEN == 64);
         3'b110:                 ok = (XLEN == 64) & ~st;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [2:0] f3);
      logic m;
      case (f3[1:0])
         2'd0:    m = 1'b0;
         2'd1:    m = a[0];
         2'd2:    m = |a[1:0];
         default: m = |a[2:0];
      endcase
      return m;
   endfunction

   function automatic logic [BW-1:0] size_mask(input logic [1:0] sz);
      logic [BW-1:0] m;
      case (sz)
         2'd0:    m = BW'(8'h01);
         2'd1:    m = BW'(8'h03);
         2'd2:    m = BW'(8'h0f);
         default: m = BW'(8'hff);
      endcase
      return m;
   endfunction

   // Both beats are concatenated so a split load extends exactly like a single-beat one.
   function automatic logic [XLEN-1:0] ld_ext(input logic [2*XLEN-1:0] beats,
                                              input logic [OW-1:0] o, input logic [2:0] f3);
      logic [2*XLEN-1:0] s;
      logic [XLEN-1:0]   keep;
      logic              sgn;
      s = beats >> {o, 3'b000};
      case (f3[1:0])
         2'd0:    begin keep = XLEN'(8'hff);         sgn = s[7];  end
         2'd1:    begin keep = XLEN'(16'hffff);      sgn = s[15]; end
         2'd2:    begin keep = XLEN'(32'hffff_ffff); sgn = s[31]; end
         default: begin keep = '1;                   sgn = s[63]; end
      endcase
      sgn = sgn & ~f3[2];
      return (s[XLEN-1:0] & keep) | (sgn ? ~keep : '0);
   endfunction

   assign off     = addr_q[OW-1:0];
   assign be_full = size_mask(f3_q[1:0]) << off;
   assign wd_full = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
   assign base    = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
   assign beat1   = (state_q == REQ1);

`ifdef LSU_MISALIGN_SPLIT_EN
   assign split_need = misaligned(addr_q, f3_q);
`else
   assign split_need = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      f3_d       = f3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      fault_d    = fault_q;
      beat0_d    = beat0_q;
      rdata_d    = rdata_q;
      outport_d  = outport_q;
      case (state_q)
         IDLE: if (req_valid) begin
            is_store_d = req_is_store;
            f3_d       = req_funct3;
            addr_d     = req_addr;
            wdata_d    = req_wdata;
            fault_d    = 1'b0;
            rdata_d    = '0;
            if (!f3_legal(req_funct3, req_is_store)) begin
               fault_d = 1'b1;
               state_d = RESP;
            end else if (req_is_store && req_addr == OUTPORT_ADDR && req_funct3 == 3'b010) begin
               outport_d = XLEN'(req_wdata[31:0]);
               state_d   = RESP;
`ifndef LSU_MISALIGN_SPLIT_EN
            end else if (misaligned(req_addr, req_funct3)) begin
               fault_d = 1'b1;
               state_d = RESP;
`endif
            end else begin
               state_d = REQ0;
            end
         end
         REQ0: if (mem_req_ready) begin
            if (!is_store_q)     state_d = WAIT0;
            else if (split_need) state_d = REQ1;
            else                 state_d = RESP;
         end
         WAIT0: if (mem_rvalid) begin
            beat0_d = mem_rdata;
            if (split_need) begin
               state_d = REQ1;
            end else begin
               rdata_d = ld_ext({{XLEN{1'b0}}, mem_rdata}, off, f3_q);
               state_d = RESP;
            end
         end
         REQ1: if (mem_req_ready) state_d = is_store_q ? RESP : WAIT1;
         WAIT1: if (mem_rvalid) begin
            rdata_d = ld_ext({mem_rdata, beat0_q}, off, f3_q);
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         f3_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         fault_q    <= 1'b0;
         beat0_q    <= '0;
         rdata_q    <= '0;
         outport_q  <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         f3_q       <= f3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         fault_q    <= fault_d;
         beat0_q    <= beat0_d;
         rdata_q    <= rdata_d;
         outport_q  <= outport_d;
      end
   end

   // Memory-side fields are gated by valid so they read zero whenever no beat is offered.
   assign req_ready     = (state_q == IDLE);
   assign mem_req_valid = (state_q == REQ0) || beat1;
   assign mem_we        = mem_req_valid & is_store_q;
   assign mem_addr      = mem_req_valid ? (beat1 ? base + ADDR_W'(NB) : base) : '0;
   assign mem_be        = mem_req_valid ? (beat1 ? be_full[BW-1:NB] : be_full[NB-1:0]) : '0;
   assign mem_wdata     = mem_req_valid ? (beat1 ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0]) : '0;
   assign resp_valid    = (state_q == RESP);
   assign resp_fault    = resp_valid & fault_q;
   assign resp_rdata    = resp_valid ? rdata_q : '0;
   assign outport       = outport_q;

endmodule

// File: tb/tb_lsu_core.sv
// Scoreboard bench for lsu_core (XLEN=32): directed requests, memory responder, response monitor.
module tb_lsu_core;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] outport;

   lsu_core dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .outport(outport)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] rdata; logic fault; int lat; int acc; } resp_t;
   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } beat_t;

   resp_t       exp_q[$];
   beat_t       beat_q[$];
   logic [31:0] rd_q[$];
   int checks = 0, errors = 0, cyc = 0;
   int ready_wait = 0, wait_cnt = 0;
   bit rv_pending = 0, suppress_rv = 0, force_rv = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
      beat_t b;
      b.addr = a; b.we = we; b.be = be; b.wdata = wd;
      beat_q.push_back(b);
   endtask

   // Memory responder: checks each offered beat, stalls ready for ready_wait cycles, returns read data.
   initial begin
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (rv_pending) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
            rv_pending = 0;
         end
         if (force_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hdead0000;
         end
         mem_req_ready = 1'b0;
         if (mem_req_valid) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
               mem_req_ready = 1'b1;
            end else begin
               chk("beat_addr",  mem_addr,  beat_q[0].addr);
               chk("beat_we",    mem_we,    beat_q[0].we);
               chk("beat_be",    mem_be,    beat_q[0].be);
               if (beat_q[0].we) chk("beat_wdata", mem_wdata, beat_q[0].wdata);
               if (wait_cnt < ready_wait) begin
                  wait_cnt++;
               end else begin
                  mem_req_ready = 1'b1;
                  wait_cnt = 0;
                  if (!beat_q[0].we && !suppress_rv) rv_pending = 1;
                  void'(beat_q.pop_front());
               end
            end
         end
      end
   end

   // Response monitor.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_rdata",   resp_rdata, e.rdata);
               chk("resp_fault",   resp_fault, e.fault);
               chk("resp_latency", cyc - e.acc, e.lat);
            end
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit expect_resp, input logic [31:0] rd, input logic flt, input int lat);
      resp_t e;
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("accept_timeout", 0, 1);
      if (expect_resp) begin
         e.rdata = rd; e.fault = flt; e.lat = lat; e.acc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic flt, input int lat);
      int n = 0;
      issue(st, f3, a, wd, 1, rd, flt, lat);
      while ((exp_q.size() != 0 || beat_q.size() != 0) && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) begin
         chk("resp_timeout", 0, 1);
         exp_q.delete(); beat_q.delete(); rd_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_fault", resp_fault, 0);
      chk("rst_mem_valid",  mem_req_valid, 0);
      chk("rst_mem_we",     mem_we, 0);
      chk("rst_mem_addr",   mem_addr, 0);
      chk("rst_mem_wdata",  mem_wdata, 0);
      chk("rst_mem_be",     mem_be, 0);
      chk("rst_outport",    outport, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);

      // load byte signed at lane 3
      beat(32'h100, 0, 4'h8, 0); rd_q.push_back(32'h80ffffff);
      run(0, 3'b000, 32'h103, 0, 32'hffffff80, 0, 3);
      // output-port store
      run(1, 3'b010, 32'hfffc, 32'h12345678, 0, 0, 1);
      chk("outport_write", outport, 32'h12345678);
      // half-unsigned load with 4-cycle ready stall
      ready_wait = 4;
      beat(32'h100, 0, 4'hc, 0); rd_q.push_back(32'hbeef0000);
      run(0, 3'b101, 32'h102, 0, 32'h0000beef, 0, 7);
      ready_wait = 0;
      // misaligned word load
`ifdef LSU_MISALIGN_SPLIT_EN
      beat(32'h100, 0, 4'h8, 0); rd_q.push_back(32'h11223344);
      beat(32'h104, 0, 4'h7, 0); rd_q.push_back(32'h55667788);
      run(0, 3'b010, 32'h103, 0, 32'h66778811, 0, 5);
      beat(32'h100, 1, 4'h8, 32'hef000000);
      beat(32'h104, 1, 4'h1, 32'h000000be);
      run(1, 3'b001, 32'h103, 32'h0000beef, 0, 0, 3);
`else
      run(0, 3'b010, 32'h103, 0, 0, 1, 1);
      run(1, 3'b001, 32'h103, 32'h0000beef, 0, 1, 1);
`endif
      // illegal codes
      run(0, 3'b111, 32'h100, 0, 0, 1, 1);
      run(1, 3'b101, 32'h100, 32'h1234, 0, 1, 1);
      run(0, 3'b011, 32'h100, 0, 0, 1, 1);
      chk("outport_kept_on_fault", outport, 32'h12345678);
      // ordinary stores and loads
      beat(32'h200, 1, 4'h2, 32'hfe00ab00);
      run(1, 3'b000, 32'h201, 32'hcafe00ab, 0, 0, 2);
      beat(32'hfffc, 1, 4'h3, 32'h0000a5a5);
      run(1, 3'b001, 32'hfffc, 32'h0000a5a5, 0, 0, 2);
      chk("outport_kept_half_store", outport, 32'h12345678);
      beat(32'h104, 0, 4'hc, 0); rd_q.push_back(32'h80011234);
      run(0, 3'b001, 32'h106, 0, 32'hffff8001, 0, 3);
      beat(32'h200, 0, 4'hf, 0); rd_q.push_back(32'hdeadbeef);
      run(0, 3'b010, 32'h200, 0, 32'hdeadbeef, 0, 3);
      beat(32'h100, 0, 4'h2, 0); rd_q.push_back(32'h00009900);
      run(0, 3'b100, 32'h101, 0, 32'h00000099, 0, 3);

      // reset while waiting for read data
      suppress_rv = 1;
      beat(32'h200, 0, 4'hf, 0);
      issue(0, 3'b010, 32'h200, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("abandon_beat_issued", beat_q.size(), 0);
      rst_n = 1'b0;
      #1;
      chk("abandon_resp_valid", resp_valid, 0);
      chk("abandon_mem_valid", mem_req_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      suppress_rv = 0; force_rv = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("abandon_no_resp", resp_valid, 0);
         chk("abandon_req_ready", req_ready, 1);
         chk("abandon_rdata", resp_rdata, 0);
      end
      force_rv = 0;
      chk("abandon_outport", outport, 0);
      chk("abandon_mem_addr", mem_addr, 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
